// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared types and sizing helpers for the digit-serial subtractor
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of digit steps needed to cover the full operand width
    function automatic int calc_cycles(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit counter width; never narrower than one bit so CYCLES = 1 still has a register
    function automatic int calc_cnt_w(input int width, input int digit);
        int cyc;
        cyc = width / digit;
        return (cyc <= 1) ? 1 : $clog2(cyc);
    endfunction

endpackage

// File: rtl/serial_subtractor_digit.sv
// rtl/serial_subtractor_digit.sv - one-digit ripple adder slice built from full adder cells
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    // Single-bit sum and majority carry
    always_comb begin
        s_o = a_i ^ b_i ^ c_i;
        c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end

endmodule

module subtract_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y_inv,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    // The subtrahend arrives pre-inverted, so x + y_inv + cin is x - y - borrow in
    logic [DIGIT:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[DIGIT];

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a_i (x[i]),
            .b_i (y_inv[i]),
            .c_i (carry[i]),
            .s_o (s[i]),
            .c_o (carry[i+1])
        );
    end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial two's-complement subtractor with valid/ready handshakes
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow,
    output logic             busy
);

    localparam int CYCLES = calc_cycles(WIDTH, DIGIT);
    localparam int CNT_W  = calc_cnt_w(WIDTH, DIGIT);
    localparam int MSB    = WIDTH - 1;

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_subtractor: DIGIT must divide WIDTH");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  nb_q, nb_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
    logic              ovf_q, ovf_d;

    int                dig_idx;
    logic [DIGIT-1:0]  dig_a;
    logic [DIGIT-1:0]  dig_nb;
    logic [DIGIT-1:0]  dig_s;
    logic              dig_cout;
    logic [WIDTH-1:0]  res_upd;
    logic              last_dig;

    // Select the active digit of each latched operand
    always_comb begin
        dig_idx  = int'(cnt_q) * DIGIT;
        dig_a    = a_q[dig_idx +: DIGIT];
        dig_nb   = nb_q[dig_idx +: DIGIT];
        last_dig = (cnt_q == CNT_W'(CYCLES - 1));
    end

    subtract_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x     (dig_a),
        .y_inv (dig_nb),
        .cin   (carry_q),
        .s     (dig_s),
        .cout  (dig_cout)
    );

    // Merge the freshly computed digit into the partial result
    always_comb begin
        res_upd                    = res_q;
        res_upd[dig_idx +: DIGIT]  = dig_s;
    end

    // Next-state logic for the FSM, datapath and result flags
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        nb_d    = nb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    nb_d    = ~b;
                    carry_d = ~bin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = res_upd;
                carry_d = dig_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_dig) begin
                    diff_d  = res_upd;
                    bout_d  = ~dig_cout;
                    // nb_q holds ~b, so equal MSBs here mean the operand signs differ
                    ovf_d   = (a_q[MSB] == nb_q[MSB]) && (res_upd[MSB] != a_q[MSB]);
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            nb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and randomized checks of the digit-serial subtractor
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, bin, out_valid, out_ready, bout, overflow, busy;
    logic [7:0] a, b, diff;

    logic        r_in_valid, r_out_ready, r_bin;
    logic [31:0] r_a, r_b;
    logic [3:0]  r_in_ready, r_out_valid, r_bout, r_ovf, r_busy;
    logic [31:0] r_diff [4];

    int checks = 0;
    int passes = 0;
    int dgs [4] = '{1, 4, 8, 32};

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .overflow(overflow), .busy(busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_reg
        localparam int DG = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 32;
        serial_subtractor #(.WIDTH(32), .DIGIT(DG)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid), .in_ready(r_in_ready[g]),
            .a(r_a), .b(r_b), .bin(r_bin), .out_valid(r_out_valid[g]), .out_ready(r_out_ready),
            .diff(r_diff[g]), .bout(r_bout[g]), .overflow(r_ovf[g]), .busy(r_busy[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic on the mathematical definition
    function automatic logic [33:0] model(input int w, input longint unsigned ma,
                                          input longint unsigned mb, input bit mbin);
        longint unsigned mask, d;
        bit bo, ov, sa, sb, sd;
        mask = (longint'(1) << w) - 1;
        d    = (ma - mb - longint'(mbin)) & mask;
        bo   = (ma < mb + longint'(mbin));
        sa   = ma[w-1];
        sb   = mb[w-1];
        sd   = d[w-1];
        ov   = (sa != sb) && (sd != sa);
        return {ov, bo, d[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called just after a falling edge; ends just after a falling edge
    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                         input logic [7:0] ed, input logic ebo, input logic eov);
        int lat;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = ~ta; b = ~tb; bin = ~tbin;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd2);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bout), 32'(ebo));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eov));
        @(negedge clk);
        chk({tag, "_idle"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        int lat;
        logic [3:0] done;
        logic [33:0] exp;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
        r_in_valid = 1'b0; r_out_ready = 1'b1; r_a = '0; r_b = '0; r_bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", {22'd0, diff, bout, overflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("sub_5_3",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        do_op("sub_3_5",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        do_op("ovf_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        do_op("ovf_7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        do_op("bin_00_00", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        do_op("bin_10_0f", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);

        // Backpressure: hold DONE for five cycles while offering another operand pair
        out_ready = 1'b0; a = 8'h20; b = 8'h09; bin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            a = 8'h55; b = 8'h11; bin = 1'b1; in_valid = 1'b1;
            @(negedge clk);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_result", {22'd0, diff, bout, overflow}, {22'd0, 8'h17, 1'b0, 1'b0});
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 32'({out_valid, in_ready}), 32'b01);
        chk("bp_diff_kept", 32'(diff), 32'h17);
        do_op("bp_next", 8'h40, 8'h41, 1'b0, 8'hFF, 1'b1, 1'b0);

        // Asynchronous reset in the middle of RUN
        a = 8'h33; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 32'({in_ready, out_valid, busy}), 32'b100);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("after_rst", 8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);

        // Randomized regression, WIDTH=32 with several digit sizes in parallel
        for (int it = 0; it < 40; it++) begin
            for (int g = 0; g < 4; g++) chk("rnd_in_ready", 32'(r_in_ready[g]), 32'd1);
            r_a = pick(); r_b = pick(); r_bin = 1'($urandom_range(0, 1)); r_in_valid = 1'b1;
            exp = model(32, longint'(r_a), longint'(r_b), r_bin);
            @(negedge clk);
            r_in_valid = 1'b0; r_a = $urandom; r_b = $urandom;
            done = '0;
            lat  = 0;
            while (done != 4'hF && lat < 40) begin
                @(negedge clk);
                lat++;
                for (int g = 0; g < 4; g++) begin
                    if (!done[g] && r_out_valid[g]) begin
                        done[g] = 1'b1;
                        chk("rnd_latency", 32'(lat), 32'(32 / dgs[g]));
                        chk("rnd_diff", r_diff[g], exp[31:0]);
                        chk("rnd_bout", 32'(r_bout[g]), 32'(exp[32]));
                        chk("rnd_ovf", 32'(r_ovf[g]), 32'(exp[33]));
                    end
                end
            end
            chk("rnd_all_done", 32'(done), 32'hF);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
